// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: control-state encodings and counter defaults.
// No logic; imported by the hazard controller, its interface and its sub-modules.
package hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2,
      ST_BAD    = 2'd3
   } ctrl_state_e;

   localparam int DEF_CNT_WIDTH   = 16;
   localparam int DRAIN_CNT_WIDTH = 4;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline stages and the hazard controller.
// Pure wiring; master drives the ID/EX observations, slave returns the stage enables.
interface hazard_ctrl_if
   import hazard_ctrl_pkg::*;
#(
   parameter int REG_NUM_BITWIDTH = 5,
   parameter int CNT_WIDTH        = DEF_CNT_WIDTH
);
   logic [REG_NUM_BITWIDTH-1:0] id_Rs1;
   logic [REG_NUM_BITWIDTH-1:0] id_Rs2;
   logic                        id_usesRs1;
   logic                        id_usesRs2;
   logic                        ex_memRead;
   logic [REG_NUM_BITWIDTH-1:0] ex_regToWrite;
   logic                        ex_branchTaken;
   logic                        halt_req;
   logic                        cnt_clr;

   logic                        pcWrite;
   logic                        ifidWrite;
   logic                        ifidFlush;
   logic                        doNOP;
   logic                        halted;
   logic [1:0]                  ctrl_state;
   logic [CNT_WIDTH-1:0]        stall_cnt;
   logic [CNT_WIDTH-1:0]        flush_cnt;

   modport master (
      output id_Rs1, id_Rs2, id_usesRs1, id_usesRs2, ex_memRead, ex_regToWrite,
             ex_branchTaken, halt_req, cnt_clr,
      input  pcWrite, ifidWrite, ifidFlush, doNOP, halted, ctrl_state, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_Rs1, id_Rs2, id_usesRs1, id_usesRs2, ex_memRead, ex_regToWrite,
             ex_branchTaken, halt_req, cnt_clr,
      output pcWrite, ifidWrite, ifidFlush, doNOP, halted, ctrl_state, stall_cnt, flush_cnt
   );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear (clear beats increment).
// Latency: count visible the cycle after inc_i; no backpressure.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [WIDTH-1:0] cnt_o
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, drain-then-halt sequencing.
// Latency: 0 (outputs combinational from state + inputs); backpressure via pcWrite/ifidWrite low.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int REG_NUM_BITWIDTH = 5,
   parameter int CNT_WIDTH        = DEF_CNT_WIDTH,
   parameter int DRAIN_CYCLES     = 3
) (
   input logic          clk,
   input logic          rst_n,
   hazard_ctrl_if.slave bus
);

   localparam logic [DRAIN_CNT_WIDTH-1:0] DRAIN_LOAD = DRAIN_CNT_WIDTH'(DRAIN_CYCLES - 1);

   ctrl_state_e                state_q, state_d;
   logic [DRAIN_CNT_WIDTH-1:0] drain_q, drain_d;
   logic                       load_use;
   logic                       stall_inc;
   logic                       pc_wr, ifid_wr, ifid_fl, do_nop, hlt;

   assign load_use = bus.ex_memRead && (bus.ex_regToWrite != '0) &&
                     ((bus.id_usesRs1 && (bus.id_Rs1 == bus.ex_regToWrite)) ||
                      (bus.id_usesRs2 && (bus.id_Rs2 == bus.ex_regToWrite)));

   always_comb begin
      state_d   = state_q;
      drain_d   = drain_q;
      pc_wr     = 1'b0;
      ifid_wr   = 1'b0;
      ifid_fl   = 1'b0;
      do_nop    = 1'b1;
      hlt       = 1'b0;
      stall_inc = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (bus.ex_branchTaken) begin
               pc_wr   = 1'b1;
               ifid_wr = 1'b1;
               ifid_fl = 1'b1;
            end else if (load_use) begin
               stall_inc = 1'b1;
            end else begin
               pc_wr   = 1'b1;
               ifid_wr = 1'b1;
               do_nop  = 1'b0;
               if (bus.halt_req) begin
                  state_d = ST_DRAIN;
                  drain_d = DRAIN_LOAD;
               end
            end
         end
         ST_DRAIN: begin
            // Fetch keeps redirecting on a resolved branch so the PC is right when we resume.
            pc_wr   = bus.ex_branchTaken;
            ifid_fl = bus.ex_branchTaken;
            if (!bus.halt_req) begin
               state_d = ST_RUN;
            end else if (drain_q == '0) begin
               state_d = ST_HALTED;
            end else begin
               drain_d = drain_q - DRAIN_CNT_WIDTH'(1);
            end
         end
         ST_HALTED: begin
            hlt = 1'b1;
            if (!bus.halt_req) begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
      if (!rst_n) begin
         pc_wr     = 1'b0;
         ifid_wr   = 1'b0;
         ifid_fl   = 1'b0;
         do_nop    = 1'b1;
         hlt       = 1'b0;
         stall_inc = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
      end
   end

   sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (stall_inc),
      .clr_i (bus.cnt_clr),
      .cnt_o (bus.stall_cnt)
   );

   sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (ifid_fl),
      .clr_i (bus.cnt_clr),
      .cnt_o (bus.flush_cnt)
   );

   assign bus.pcWrite    = pc_wr;
   assign bus.ifidWrite  = ifid_wr;
   assign bus.ifidFlush  = ifid_fl;
   assign bus.doNOP      = do_nop;
   assign bus.halted     = hlt;
   assign bus.ctrl_state = rst_n ? state_q : ST_RUN;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expectations queued at stimulus time, checked by a monitor.
module tb_hazard_ctrl;

   logic clk;
   logic rst_n;

   hazard_ctrl_if #(.REG_NUM_BITWIDTH(5), .CNT_WIDTH(16)) hif ();

   hazard_ctrl #(.REG_NUM_BITWIDTH(5), .CNT_WIDTH(16), .DRAIN_CYCLES(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (hif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [4:0]  o;    // {pcWrite, ifidWrite, ifidFlush, doNOP, halted}
      logic [1:0]  st;
      logic [15:0] sc;
      logic [15:0] fc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   stim_done = 1'b0;

   task automatic apply(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic mr, input logic [4:0] rd,
                        input logic br, input logic hr, input logic clr);
      @(posedge clk);
      #1;
      rst_n              = rst;
      hif.id_Rs1         = rs1;
      hif.id_Rs2         = rs2;
      hif.id_usesRs1     = u1;
      hif.id_usesRs2     = u2;
      hif.ex_memRead     = mr;
      hif.ex_regToWrite  = rd;
      hif.ex_branchTaken = br;
      hif.halt_req       = hr;
      hif.cnt_clr        = clr;
   endtask

   task automatic vec(input string nm, input logic rst, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic u1, input logic u2, input logic mr,
                      input logic [4:0] rd, input logic br, input logic hr, input logic clr,
                      input logic [4:0] eo, input logic [1:0] est, input logic [15:0] esc,
                      input logic [15:0] efc);
      exp_t e;
      apply(rst, rs1, rs2, u1, u2, mr, rd, br, hr, clr);
      e.name = nm;
      e.o    = eo;
      e.st   = est;
      e.sc   = esc;
      e.fc   = efc;
      exp_q.push_back(e);
   endtask

   initial begin : monitor
      exp_t       e;
      logic [4:0] ao;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            ao = {hif.pcWrite, hif.ifidWrite, hif.ifidFlush, hif.doNOP, hif.halted};
            checks++;
            if (ao !== e.o || hif.ctrl_state !== e.st || hif.stall_cnt !== e.sc ||
                hif.flush_cnt !== e.fc) begin
               errors++;
               $display("FAIL %s: got pc/ifw/ifl/nop/hlt=%b st=%0d sc=%h fc=%h, want %b st=%0d sc=%h fc=%h",
                        e.name, ao, hif.ctrl_state, hif.stall_cnt, hif.flush_cnt,
                        e.o, e.st, e.sc, e.fc);
            end
         end
      end
   end

   initial begin : stimulus
      rst_n              = 1'b0;
      hif.id_Rs1         = '0;
      hif.id_Rs2         = '0;
      hif.id_usesRs1     = 1'b0;
      hif.id_usesRs2     = 1'b0;
      hif.ex_memRead     = 1'b0;
      hif.ex_regToWrite  = '0;
      hif.ex_branchTaken = 1'b0;
      hif.halt_req       = 1'b0;
      hif.cnt_clr        = 1'b0;

      //   name         rst rs1 rs2 u1 u2 mr rd br hr clr  pc/ifw/ifl/nop/hlt st sc fc
      vec("reset",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00010, 0, 16'd0, 16'd0);
      vec("idle",        1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 0, 16'd0, 16'd0);
      vec("load_use2",   1, 0, 5, 0, 1, 1, 5, 0, 0, 0, 5'b00010, 0, 16'd0, 16'd0);
      vec("stall_inc",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 0, 16'd1, 16'd0);
      vec("rd_zero",     1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 5'b11000, 0, 16'd1, 16'd0);
      vec("rs2_unused",  1, 0, 5, 0, 0, 1, 5, 0, 0, 0, 5'b11000, 0, 16'd1, 16'd0);
      vec("load_use1",   1, 7, 0, 1, 0, 1, 7, 0, 0, 0, 5'b00010, 0, 16'd1, 16'd0);
      vec("not_load",    1, 7, 0, 1, 0, 0, 7, 0, 0, 0, 5'b11000, 0, 16'd2, 16'd0);
      vec("br_over_lu",  1, 0, 5, 0, 1, 1, 5, 1, 0, 0, 5'b11110, 0, 16'd2, 16'd0);
      vec("flush_inc",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 0, 16'd2, 16'd1);
      // Full drain to HALTED, then release.
      vec("halt_run",    1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b11000, 0, 16'd2, 16'd1);
      vec("drain1",      1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00010, 1, 16'd2, 16'd1);
      vec("drain2_lu",   1, 0, 5, 0, 1, 1, 5, 0, 1, 0, 5'b00010, 1, 16'd2, 16'd1);
      vec("drain3",      1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00010, 1, 16'd2, 16'd1);
      vec("halted",      1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00011, 2, 16'd2, 16'd1);
      vec("halted_br",   1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 5'b00011, 2, 16'd2, 16'd1);
      vec("halt_rel",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00011, 2, 16'd2, 16'd1);
      vec("resume",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 0, 16'd2, 16'd1);
      // Abort on the second drain cycle with a taken branch.
      vec("halt_run2",   1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b11000, 0, 16'd2, 16'd1);
      vec("abort_d1",    1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00010, 1, 16'd2, 16'd1);
      vec("abort_br",    1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b10110, 1, 16'd2, 16'd1);
      vec("abort_run",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 0, 16'd2, 16'd2);
      vec("abort_run2",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 0, 16'd2, 16'd2);

      // Bring stall_cnt from 2 up to 0xFFFF with unchecked stall cycles.
      for (int i = 0; i < 65533; i++) begin
         apply(1, 0, 5, 0, 1, 1, 5, 0, 0, 0);
      end
      vec("sat_stall",   1, 0, 5, 0, 1, 1, 5, 0, 0, 0, 5'b00010, 0, 16'hFFFF, 16'd2);
      vec("sat_hold",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 0, 16'hFFFF, 16'd2);
      vec("clr_stall",   1, 0, 5, 0, 1, 1, 5, 0, 0, 1, 5'b00010, 0, 16'hFFFF, 16'd2);
      vec("cleared",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 0, 16'd0, 16'd0);
      vec("pre_stall",   1, 0, 5, 0, 1, 1, 5, 0, 0, 0, 5'b00010, 0, 16'd0, 16'd0);
      vec("pre_br",      1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b11110, 0, 16'd1, 16'd0);
      vec("pre_halt",    1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b11000, 0, 16'd1, 16'd1);
      vec("pre_drain",   1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00010, 1, 16'd1, 16'd1);
      vec("rst_drain",   0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00010, 0, 16'd0, 16'd0);
      vec("post_rst",    1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b11000, 0, 16'd0, 16'd0);
      vec("post_drain",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00010, 1, 16'd0, 16'd0);
      vec("post_run",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 0, 16'd0, 16'd0);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
         @(negedge clk);
      end
      #1;
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain_queue: %0d expectations left unchecked, want 0", exp_q.size());
      end
      stim_done = 1'b1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter REG_NUM_BITWIDTH, default 5, register-index width.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16, statistics counter width.
REQ-003 The block SHALL have parameter DRAIN_CYCLES, default 3, range 1..15, cycles spent in DRAIN before HALTED.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 id_Rs1, id_Rs2  in  REG_NUM_BITWIDTH each  source registers of the instruction in ID.
REQ-008 id_usesRs1, id_usesRs2  in  1 each  the ID instruction actually reads that source.
REQ-009 ex_memRead  in  1  the instruction in EX is a load.
REQ-010 ex_regToWrite  in  REG_NUM_BITWIDTH  destination of the instruction in EX.
REQ-011 ex_branchTaken  in  1  EX resolved a taken branch or jump this cycle.
REQ-012 halt_req  in  1  level request to drain and freeze the pipeline.
REQ-013 cnt_clr  in  1  synchronous clear of both statistics counters.
REQ-014 pcWrite  out  1  PC update enable.
REQ-015 ifidWrite  out  1  IF/ID register load enable.
REQ-016 ifidFlush  out  1  IF/ID contents replaced by a NOP.
REQ-017 doNOP  out  1  zeroes the ID/EX control fields (bubble).
REQ-018 halted  out  1  the pipeline is frozen.
REQ-019 ctrl_state  out  2  current state: RUN=0, DRAIN=1, HALTED=2.
REQ-020 stall_cnt, flush_cnt  out  CNT_WIDTH each  saturating event counters.

Function
REQ-021 load_use SHALL equal ex_memRead AND ex_regToWrite != 0 AND ((id_usesRs1 AND id_Rs1 == ex_regToWrite) OR (id_usesRs2 AND id_Rs2 == ex_regToWrite)).
REQ-022 Outputs SHALL be combinational from state and current inputs, with zero latency.
REQ-023 In RUN, priority SHALL be ex_branchTaken > load_use > halt_req.
REQ-024 In RUN with ex_branchTaken: pcWrite=1, ifidWrite=1, ifidFlush=1, doNOP=1; state stays RUN.
REQ-025 In RUN with load_use and no branch: pcWrite=0, ifidWrite=0, ifidFlush=0, doNOP=1; state stays RUN.
REQ-026 In RUN with halt_req and neither event: the idle outputs of REQ-027 SHALL apply, the next state SHALL be DRAIN, and the drain counter SHALL be loaded with DRAIN_CYCLES-1.
REQ-027 In RUN otherwise: pcWrite=1, ifidWrite=1, ifidFlush=0, doNOP=0.
REQ-028 In DRAIN: ifidWrite=0, doNOP=1, pcWrite=ex_branchTaken, ifidFlush=ex_branchTaken; load_use SHALL be ignored.
REQ-029 In DRAIN, halt_req low SHALL return the state to RUN next cycle (abort); otherwise the drain counter SHALL decrement, and at count 0 the next state SHALL be HALTED.
REQ-030 In HALTED: halted=1, pcWrite=0, ifidWrite=0, ifidFlush=0, doNOP=1; halt_req low SHALL give RUN next cycle.
REQ-031 halted SHALL be 1 only in HALTED.
REQ-032 Encoding 3 SHALL be unreachable; if it is entered, the next state SHALL be RUN.
REQ-033 stall_cnt SHALL increment in each cycle where REQ-025 applies.
REQ-034 flush_cnt SHALL increment in each cycle where ifidFlush=1.
REQ-035 Both counters SHALL saturate at all-ones.
REQ-036 cnt_clr SHALL zero both counters and takes priority over a same-cycle increment.

Reset
REQ-037 While rst_n=0: state RUN, drain counter 0, stall_cnt=0, flush_cnt=0.
REQ-038 While rst_n=0, outputs SHALL be forced to pcWrite=0, ifidWrite=0, ifidFlush=0, doNOP=1, halted=0, ctrl_state=0.
REQ-039 Reset assertion in DRAIN or HALTED SHALL abandon the drain immediately; after deassertion the state is RUN.

Structure
REQ-040 State encodings (RUN/DRAIN/HALTED) and default CNT_WIDTH SHALL live in the shared pipeline package.
REQ-041 A single sub-module sat_counter (increment, clear, saturate; parameter width) SHALL be instantiated twice.

Verification
REQ-042 Stimulus: ex_memRead=1, ex_regToWrite=5, id_Rs2=5, id_usesRs2=1 for 1 cycle. Response: pcWrite=0, ifidWrite=0, doNOP=1; stall_cnt 0->1.
REQ-043 Stimulus: same as REQ-042 but ex_regToWrite=0, or id_usesRs2=0. Response: no stall, doNOP=0, stall_cnt unchanged.
REQ-044 Stimulus: ex_branchTaken=1 together with a load_use match. Response: ifidFlush=1, pcWrite=1, doNOP=1; flush_cnt+1, stall_cnt unchanged.
REQ-045 Stimulus: halt_req held high from RUN, DRAIN_CYCLES=3. Response: ctrl_state 0,1,1,1,2; halted=1 from the 5th cycle; halt_req low gives RUN next cycle with pcWrite=1.
REQ-046 Stimulus: halt_req dropped on the 2nd DRAIN cycle, with ex_branchTaken=1 that cycle. Response: pcWrite=1 and ifidFlush=1 that cycle; RUN next cycle; halted never 1.
REQ-047 Stimulus: preload stall_cnt to 0xFFFF, then a further stall; then cnt_clr plus a stall; then rst_n low mid-DRAIN. Response: stall_cnt stays 0xFFFF, then reads 0; after the reset pulse, state is RUN and both counters are 0.
